ctech_lib_rstb_gen: RTL and testbench
=====================================

# ctech_lib_rstb_gen

Reset generator that drives the `rb` pins of the async-reset flop cells. It accepts a raw active-low reset and produces a glitch-free `rb_out` that asserts asynchronously and deasserts synchronously, after synchronizer and hold delays. It also services a software soft-reset request through a req/ack handshake. It sits at each clock-domain root, ahead of every `msff_async_rstb`-style flop in that domain.

## Interface
- `SYNC_STAGES`, default 2: deassertion synchronizer depth; legal values 2..4.
- `HOLD_CYCLES`, default 16: cycles `rb_out` stays low after sync release or soft request; legal values 1..255.
- `CNT_W`, derived as `$clog2(HOLD_CYCLES+1)`: hold counter width; not overridable.
- `clk` input, 1 bit: the single clock. All logic is rising-edge.
- `rb` input, 1 bit: asynchronous, active-low reset. It clears every flop in the block, including the synchronizer.
- `sw_rst_req` input, 1 bit: soft-reset request, level. Held high until `sw_rst_ack` is seen.
- `rb_out` output, 1 bit: generated active-low reset. Driven directly by a flop with async clear.
- `sw_rst_ack` output, 1 bit: one-cycle pulse when a soft reset completes.
- `rst_active` output, 1 bit: high whenever the state is not RUN.

## Operation
- States:
  - RESET: `rb` low.
  - SYNC: waiting for the synchronizer.
  - HOLD: power-on hold.
  - RUN
  - SOFT: soft-reset hold.
- Reset values, forced asynchronously while `rb`=0:
  - state = RESET, synchronizer = 0, counter = 0, `armed` = 1.
  - `rb_out` = 0, `sw_rst_ack` = 0, `rst_active` = 1.
- RESET→SYNC: on the first edge with `rb`=1. The synchronizer shifts in 1 each cycle.
- SYNC→HOLD: when the last synchronizer stage reads 1. The counter loads `HOLD_CYCLES`.
- HOLD: the counter decrements each cycle. At count 1→0 the state goes to RUN and `rb_out` is registered to 1.
- RUN: `rb_out`=1. When `sw_rst_req`=1 and `armed`=1:
  - Go to SOFT, register `rb_out` to 0, load the counter with `HOLD_CYCLES`, and clear `armed`.
- SOFT: the counter decrements each cycle. At 1→0:
  - Go to RUN, register `rb_out` to 1, and register `sw_rst_ack` to 1 for exactly one cycle.
- `armed`: set on any edge where `sw_rst_req` is sampled 0. It stays clear while the request remains high after ack, so one request yields exactly one soft reset.
- A request held high through power-on is serviced once on entry to RUN, because `armed` resets to 1.
- `sw_rst_req` is ignored in RESET, SYNC, HOLD and SOFT; it is only acted on in RUN.
- `rb` falling in any state:
  - Immediate return to RESET and `rb_out`=0 with no clock required.
  - An in-flight soft reset is abandoned and no ack is issued.
- `rb` pulses shorter than one cycle still fully reset the block, and the whole SYNC+HOLD sequence restarts.
- `rb_out` comes only from a register output; no combinational path from any input except the async clear.

## Timing
- Assertion: `rb`↓ → `rb_out`↓ is asynchronous (clear-to-Q only), with zero clock edges.
- Deassertion: edge 1 is the first rising edge with `rb`=1 meeting recovery. The last sync stage is 1 after edge `SYNC_STAGES`. `rb_out` rises after edge `SYNC_STAGES+HOLD_CYCLES`.
- Soft reset: request sampled at edge N in RUN.
  - `rb_out` is low from after edge N until after edge N+`HOLD_CYCLES`, i.e. exactly `HOLD_CYCLES` cycles low.
  - `sw_rst_ack` is high for the single cycle following edge N+`HOLD_CYCLES`.
- Minimum request-to-request spacing: ack, then `sw_rst_req` low for at least 1 sampled cycle, then re-raise.
- `HOLD_CYCLES`=1: one-cycle low pulse; the ack coincides with the `rb_out` rise.

## Test plan
- Power-on (`SYNC_STAGES`=2, `HOLD_CYCLES`=4): release `rb` before edge 1 → `rb_out`=0 through edge 5, 1 after edge 6; `rst_active` falls with it; `sw_rst_ack` stays 0.
- Soft reset in RUN: raise `sw_rst_req` at edge 20 → `rb_out` low after edges 20–23, high after edge 24; `sw_rst_ack`=1 only between edges 24 and 25.
- Sticky request: hold `sw_rst_req` high for 30 cycles after ack → no second soft reset; drop for 1 cycle and re-raise → second soft reset of exactly 4 cycles.
- Async abort: drop `rb` mid-SOFT (count=2) with the clock stopped → `rb_out`=0 immediately, no ack ever.
  - After release, full 6-edge power-on sequence.
- Runt `rb` glitch: a 0.3-cycle low pulse on `rb` in RUN → `rb_out` low at once, then high again 6 edges after release.
- Request during power-on: `sw_rst_req`=1 from time 0 → soft reset begins on the first edge in RUN; `rb_out` is high exactly 1 cycle between the two low periods.

Source files
------------

// File: rtl/ctech_lib_rstb_gen.sv
// Domain-root reset generator: async assert, synchronized + held deassert of rb_out,
// plus a req/ack soft-reset sequencer. All outputs come straight from flops cleared by rb.
module ctech_lib_rstb_gen #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned HOLD_CYCLES = 16
) (
   input  logic clk,
   input  logic rb,
   input  logic sw_rst_req,
   output logic rb_out,
   output logic sw_rst_ack,
   output logic rst_active
);

   localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_RESET = 3'd0,
      ST_SYNC  = 3'd1,
      ST_HOLD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_SOFT  = 3'd4
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt;
   logic                   armed;

   // The hold is loaded on the edge where the last sync stage turns 1, so
   // rb_out rises after edge SYNC_STAGES+HOLD_CYCLES counted from release.
   always_ff @(posedge clk or negedge rb) begin
      if (!rb) begin
         state      <= ST_RESET;
         sync_q     <= '0;
         cnt        <= '0;
         armed      <= 1'b1;
         rb_out     <= 1'b0;
         sw_rst_ack <= 1'b0;
         rst_active <= 1'b1;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], 1'b1};
         sw_rst_ack <= 1'b0;
         if (!sw_rst_req) begin
            armed <= 1'b1;
         end
         unique case (state)
            ST_RESET: begin
               state <= ST_SYNC;
            end
            ST_SYNC: begin
               if (sync_q[SYNC_STAGES-2]) begin
                  state <= ST_HOLD;
                  cnt   <= HOLD_LOAD;
               end
            end
            ST_HOLD: begin
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  state      <= ST_RUN;
                  rb_out     <= 1'b1;
                  rst_active <= 1'b0;
               end
            end
            ST_RUN: begin
               // armed blocks a request still held high after its ack
               if (sw_rst_req && armed) begin
                  state      <= ST_SOFT;
                  rb_out     <= 1'b0;
                  rst_active <= 1'b1;
                  cnt        <= HOLD_LOAD;
                  armed      <= 1'b0;
               end
            end
            ST_SOFT: begin
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  state      <= ST_RUN;
                  rb_out     <= 1'b1;
                  rst_active <= 1'b0;
                  sw_rst_ack <= 1'b1;
               end
            end
            default: begin
               state      <= ST_RESET;
               rb_out     <= 1'b0;
               rst_active <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ctech_lib_rstb_gen.sv
// Scoreboard bench for ctech_lib_rstb_gen: an edge-counting reference model pushes the
// expected outputs, a separate monitor pops and compares on every clock fall or rb fall.
`timescale 1ns/100ps
module tb_ctech_lib_rstb_gen;

   localparam int S = 2;
   localparam int H = 4;

   logic clk = 1'b0;
   logic clk_en = 1'b1;
   logic rb = 1'b0;
   logic sw_rst_req = 1'b0;
   logic rb_out, sw_rst_ack, rst_active;

   typedef struct packed {
      logic rb_out;
      logic ack;
      logic act;
   } exp_t;

   exp_t exp_q[$];
   int   tag_q[$];
   int   total = 0;
   int   bad = 0;

   // reference model: edges seen with rb high since release, soft-reset end edge
   int   k = 0;
   int   soft_end = 0;
   bit   armed = 1'b1;
   bit   ack_m = 1'b0;
   int   edge_no = 0;

   ctech_lib_rstb_gen #(.SYNC_STAGES(S), .HOLD_CYCLES(H)) dut (
      .clk       (clk),
      .rb        (rb),
      .sw_rst_req(sw_rst_req),
      .rb_out    (rb_out),
      .sw_rst_ack(sw_rst_ack),
      .rst_active(rst_active)
   );

   // stopping the clock parks it low
   initial forever #5 clk = clk_en ? ~clk : 1'b0;

   function automatic void model_reset();
      k        = 0;
      soft_end = 0;
      armed    = 1'b1;
      ack_m    = 1'b0;
   endfunction

   function automatic void model_edge();
      bit run;
      ack_m = 1'b0;
      if (!rb) return;
      run = (k >= S + H) && (soft_end == 0);
      k++;
      if (soft_end != 0 && k == soft_end) begin
         soft_end = 0;
         ack_m    = 1'b1;
      end else if (run && sw_rst_req && armed) begin
         soft_end = k + H;
         armed    = 1'b0;
      end
      if (!sw_rst_req) armed = 1'b1;
   endfunction

   function automatic void push_exp();
      exp_t e;
      e.rb_out = (k >= S + H) && (soft_end == 0);
      e.ack    = ack_m;
      e.act    = !e.rb_out;
      exp_q.push_back(e);
      tag_q.push_back(edge_no);
   endfunction

   task automatic cycle(input logic req_v);
      @(posedge clk);
      edge_no++;
      model_edge();
      push_exp();
      #2;
      sw_rst_req = req_v;
   endtask

   // called 2ns after an edge; drops rb just after that cycle's check
   task automatic drop_rb();
      #4.5;
      model_reset();
      push_exp();
      rb = 1'b0;
   endtask

   task automatic runt();
      drop_rb();
      #3;
      rb = 1'b1;
   endtask

   task automatic long_drop(input int n, input logic req_v);
      drop_rb();
      repeat (n) cycle(req_v);
      rb = 1'b1;
   endtask

   task automatic check(input string nm, input int t, input logic got, input logic want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s at edge %0d: got %b expected %b", nm, t, got, want);
      end
   endtask

   // monitor
   initial begin
      exp_t e;
      int   t;
      forever begin
         @(negedge clk or negedge rb);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check("rb_out", t, rb_out, e.rb_out);
            check("sw_rst_ack", t, sw_rst_ack, e.ack);
            check("rst_active", t, rst_active, e.act);
         end
      end
   end

   initial begin
      logic r;
      // power-on: rb held low for 3 edges, released before edge 1
      repeat (3) cycle(1'b0);
      rb = 1'b1;
      // soft request sampled at edge 20, then held (sticky) for 30 cycles after ack
      repeat (18) cycle(1'b0);
      repeat (36) cycle(1'b1);
      cycle(1'b0);
      repeat (10) cycle(1'b1);
      repeat (4) cycle(1'b0);

      // async abort mid-SOFT with count=2 and the clock stopped
      repeat (4) cycle(1'b1);
      clk_en = 1'b0;
      #5;
      sw_rst_req = 1'b0;
      model_reset();
      push_exp();
      rb = 1'b0;
      #20;
      rb = 1'b1;
      #3;
      clk_en = 1'b1;
      repeat (12) cycle(1'b0);

      // 0.3-cycle runt in RUN
      runt();
      repeat (12) cycle(1'b0);

      // request held from reset through power-on
      long_drop(3, 1'b1);
      repeat (20) cycle(1'b1);
      repeat (3) cycle(1'b0);

      // randomized requests and resets
      repeat (600) begin
         int sel;
         sel = int'($urandom_range(0, 99));
         if (sel < 2) begin
            runt();
         end else if (sel < 4) begin
            long_drop(int'($urandom_range(1, 3)), sw_rst_req);
         end else begin
            r = ($urandom_range(0, 9) < 2) ? ~sw_rst_req : sw_rst_req;
            cycle(r);
         end
      end

      repeat (2) @(negedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
